// File: rtl/morph_win_ctrl.sv
// morph_win_ctrl: 3x3 binary window scheduler feeding erode/dilate.
// Two line buffers + column shifters; out-of-frame taps forced to 1.
module morph_win_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CW    = 10,
  parameter int RW    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pix_en,
  input  logic       pix_bin,
  input  logic [1:0] mode_req,
  input  logic       mode_wr,
  output logic       p11,
  output logic       p12,
  output logic       p13,
  output logic       p21,
  output logic       p22,
  output logic       p23,
  output logic       p31,
  output logic       p32,
  output logic       p33,
  output logic       win_en,
  output logic [1:0] op_sel,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] COL_MAX = CW'(H_ACT - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_ACT - 1);

  state_t state_q, state_d;

  logic vs_q, vs_qq;
  logic fs, acc, last;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [1:0] pend_q, pend_d;
  logic [1:0] op_q, op_d;
  logic [1:0] req_m;

  logic busy_q, done_q, win_en_q;
  logic ovf_q, ovf_d;
  logic post_q, post_d;

  logic [H_ACT-1:0] lb0_q, lb1_q;
  logic lb0_rd, lb1_rd;

  // Columns 2..3 of each row, unmasked: {r1c2,r1c3,r2c2,r2c3,r3c2,r3c3}
  logic [5:0] raw_q, raw_d;
  logic [8:0] raw_new, mask, win_d, win_q;
  logic r0, r1, c0, c1;

  assign fs   = vs_q & ~vs_qq;
  assign acc  = pix_en & (state_q == RUN) & ~fs;
  assign last = (col_q == COL_MAX) & (row_q == ROW_MAX);

  assign req_m = (mode_req == 2'd3) ? 2'd0 : mode_req;

  assign lb0_rd = lb0_q[col_q];
  assign lb1_rd = lb1_q[col_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fs) state_d = RUN;
      end
      RUN: begin
        if (fs) state_d = RUN;
        else if (acc && last) state_d = DONE;
      end
      DONE: begin
        state_d = fs ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (fs) begin
      col_d = '0;
      row_d = '0;
    end else if (acc) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    pend_d = mode_wr ? req_m : pend_q;
    op_d   = fs ? pend_q : op_q;
    post_d = fs ? 1'b0 : (post_q | (state_q == DONE));
    ovf_d  = fs ? 1'b0
                : (ovf_q | (pix_en & (state_q == IDLE) & post_q));
  end

  assign r0 = (row_q == '0);
  assign r1 = (row_q == RW'(1));
  assign c0 = (col_q == '0);
  assign c1 = (col_q == CW'(1));

  always_comb begin
    raw_new = {raw_q[5], raw_q[4], lb1_rd,
               raw_q[3], raw_q[2], lb0_rd,
               raw_q[1], raw_q[0], pix_bin};
    raw_d   = {raw_new[7:6], raw_new[4:3], raw_new[1:0]};
  end

  // Rows above the frame and columns left of it read as background
  always_comb begin
    mask = '0;
    if (r0 | r1) mask[8:6] = 3'b111;
    if (r0)      mask[5:3] = 3'b111;
    if (c0 | c1) mask = mask | 9'b100_100_100;
    if (c0)      mask = mask | 9'b010_010_010;
    win_d = raw_new | mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vs_q     <= 1'b0;
      vs_qq    <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      pend_q   <= 2'd0;
      op_q     <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      win_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      post_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_q     <= vsync;
      vs_qq    <= vs_q;
      col_q    <= col_d;
      row_q    <= row_d;
      pend_q   <= pend_d;
      op_q     <= op_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
      win_en_q <= acc;
      ovf_q    <= ovf_d;
      post_q   <= post_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= '1;
      win_q <= '1;
    end else if (acc) begin
      raw_q <= raw_d;
      win_q <= win_d;
    end
  end

  // Read-before-write: LB1 takes LB0's old value, LB0 takes the pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb0_q <= '1;
      lb1_q <= '1;
    end else if (acc) begin
      lb1_q[col_q] <= lb0_rd;
      lb0_q[col_q] <= pix_bin;
    end
  end

  assign {p11, p12, p13} = win_q[8:6];
  assign {p21, p22, p23} = win_q[5:3];
  assign {p31, p32, p33} = win_q[2:0];

  assign win_en     = win_en_q;
  assign op_sel     = op_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_morph_win_ctrl.sv
// tb_morph_win_ctrl: scoreboard bench for the 3x3 window scheduler.
// Expected windows come from a per-pixel neighbourhood model.
module tb_morph_win_ctrl;

  localparam int H = 8;
  localparam int V = 4;

  logic clk = 1'b0;
  logic rst_n, vsync, pix_en, pix_bin, mode_wr;
  logic [1:0] mode_req, op_sel;
  logic p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic win_en, frame_busy, frame_done, ovf;

  int checks = 0;
  int errors = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  int wbase = 0;
  int dbase = 0;
  logic [1:0] pend_m = 2'd0;
  logic [1:0] cur_op = 2'd0;
  logic [8:0] expq[$];
  bit img [V][H];

  always #5 clk = ~clk;

  morph_win_ctrl #(
    .H_ACT(H), .V_ACT(V), .CW(3), .RW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync),
    .pix_en(pix_en), .pix_bin(pix_bin),
    .mode_req(mode_req), .mode_wr(mode_wr),
    .p11(p11), .p12(p12), .p13(p13),
    .p21(p21), .p22(p22), .p23(p23),
    .p31(p31), .p32(p32), .p33(p33),
    .win_en(win_en), .op_sel(op_sel),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .ovf(ovf)
  );

  wire [8:0] win = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] mapm(logic [1:0] q);
    return (q == 2'd3) ? 2'd0 : q;
  endfunction

  // Tap (x,y) of the window emitted for pixel (r,c) is pixel (r-2+x, c-2+y)
  function automatic logic [8:0] exp_win(int r, int c);
    logic [8:0] w;
    for (int x = 0; x < 3; x++) begin
      for (int y = 0; y < 3; y++) begin
        int sr;
        int sc;
        sr = r - 2 + x;
        sc = c - 2 + y;
        w[8 - (3 * x + y)] = (sr < 0 || sc < 0) ? 1'b1 : img[sr][sc];
      end
    end
    return w;
  endfunction

  task automatic fill_const(bit v);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = 1'($urandom_range(1));
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_taps"}, win, 9'h1FF);
    chk({tag, "_win_en"}, win_en, 0);
    chk({tag, "_op_sel"}, op_sel, 0);
    chk({tag, "_busy"}, frame_busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  task automatic mode_write(logic [1:0] req);
    mode_wr = 1'b1;
    mode_req = req;
    cyc();
    mode_wr = 1'b0;
    pend_m = mapm(req);
  endtask

  task automatic start_frame(int wr, logic [1:0] req);
    logic [1:0] e;
    e = pend_m;
    vsync = 1'b1;
    cyc();
    wbase = win_cnt;
    dbase = done_cnt;
    if (wr != 0) begin
      mode_wr = 1'b1;
      mode_req = req;
    end
    cyc();
    mode_wr = 1'b0;
    if (wr != 0) pend_m = mapm(req);
    cyc();
    cyc();
    vsync = 1'b0;
    cur_op = e;
    chk("start_busy", frame_busy, 1);
    chk("start_op_sel", op_sel, cur_op);
    chk("start_ovf", ovf, 0);
  endtask

  task automatic run_pixels(int first, int n, int gap);
    for (int k = first; k < first + n; k++) begin
      int r;
      int c;
      r = k / H;
      c = k % H;
      while ($urandom_range(99) < gap) cyc();
      pix_en = 1'b1;
      pix_bin = img[r][c];
      expq.push_back(exp_win(r, c));
      cyc();
      pix_en = 1'b0;
    end
  endtask

  task automatic end_frame();
    chk("done_after_last", frame_done, 1);
    chk("busy_fall", frame_busy, 0);
    cyc();
    chk("done_one_cycle", frame_done, 0);
    chk("win_count", win_cnt - wbase, H * V);
    chk("done_count", done_cnt - dbase, 1);
    chk("queue_drained", expq.size(), 0);
  endtask

  task automatic frame(int gap, int wr_fs, logic [1:0] fs_req,
                       int mid, logic [1:0] mid_req);
    start_frame(wr_fs, fs_req);
    if (mid != 0) begin
      run_pixels(0, 12, gap);
      mode_write(mid_req);
      chk("mid_op_hold", op_sel, cur_op);
      run_pixels(12, H * V - 12, gap);
    end else begin
      run_pixels(0, H * V, gap);
    end
    end_frame();
  endtask

  initial begin
    forever begin
      cyc();
      if (rst_n === 1'b1) begin
        if (frame_done) done_cnt++;
        if (win_en) begin
          win_cnt++;
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL win_unexpected: got %h expected none", win);
          end else begin
            logic [8:0] e;
            e = expq.pop_front();
            if (win !== e) begin
              errors++;
              $display("FAIL window: got %h expected %h", win, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst_n = 1'b0;
    vsync = 1'b0;
    pix_en = 1'b0;
    pix_bin = 1'b0;
    mode_wr = 1'b0;
    mode_req = 2'd0;
    repeat (3) cyc();
    check_reset("rst");
    rst_n = 1'b1;
    cyc();

    pix_en = 1'b1;
    repeat (3) cyc();
    pix_en = 1'b0;
    cyc();
    chk("ovf_before_first_frame", ovf, 0);

    fill_const(1'b1);
    img[2][3] = 1'b0;
    frame(0, 0, 2'd0, 1, 2'd2);

    fill_const(1'b0);
    frame(0, 1, 2'd1, 0, 2'd0);

    fill_rand();
    frame(0, 0, 2'd0, 0, 2'd0);
    frame(70, 0, 2'd0, 0, 2'd0);

    repeat (2) cyc();
    chk("ovf_clear_before_extra", ovf, 0);
    pix_en = 1'b1;
    pix_bin = 1'b1;
    repeat (5) cyc();
    pix_en = 1'b0;
    cyc();
    chk("ovf_set", ovf, 1);

    fill_rand();
    start_frame(0, 2'd0);
    d0 = dbase;
    run_pixels(0, 10, 0);
    repeat (2) cyc();
    chk("abandon_partial_wins", win_cnt - wbase, 10);
    start_frame(0, 2'd0);
    chk("abandon_no_done", done_cnt, d0);
    fill_rand();
    run_pixels(0, 12, 20);
    mode_write(2'd1);
    run_pixels(12, H * V - 12, 20);
    end_frame();

    fill_rand();
    start_frame(0, 2'd0);
    run_pixels(0, 17, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    chk("rst_queue_drained", expq.size(), 0);
    expq.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    pend_m = 2'd0;
    cyc();

    fill_rand();
    frame(50, 0, 2'd0, 1, 2'd3);

    fill_rand();
    frame(0, 0, 2'd0, 0, 2'd0);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
